// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding and default byte width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } uart_arb_state_e;

  localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the farthest offset down so the nearest hit to ptr_i wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int k;
      k = int'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req_i[k]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Optional watchdog on the end-of-frame wait: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_W         = UART_DATA_W,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_byte_ready_o,
  output logic                      tx_t_byte_o,
  input  logic                      tx_done_i,
  output logic [IDX_W-1:0]          grant_id_o,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                      timeout_o,
`endif
  output logic                      busy_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  uart_arb_state_e   state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  ptr_after;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (found),
    .idx_o   (win)
  );

  assign ptr_after = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    hold_d          = hold_q;
    req_ready_o     = '0;
    tx_byte_ready_o = 1'b0;
    tx_t_byte_o     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d           = cnt_q;
    timeout_o       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // No accept pulse while reset is asserted: the byte would be lost.
        if (found && rst_ni) begin
          req_ready_o[win] = 1'b1;
          hold_d           = req_data_i[int'(win)*DATA_W +: DATA_W];
          grant_d          = win;
          state_d          = LOAD;
        end
      end
      LOAD: begin
        tx_byte_ready_o = 1'b1;
        state_d         = START;
      end
      START: begin
        tx_t_byte_o = 1'b1;
        state_d     = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      WAIT_DONE: begin
        if (tx_done_i) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_after;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
          rr_ptr_d  = ptr_after;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      hold_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      hold_q   <= hold_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign tx_data_o  = hold_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ byte sources.
- Accepts one byte per grant through a valid/ready handshake and holds it in an internal register.
- Drives the transmitter's byte_ready/t_byte load sequence, then waits for end-of-frame before the next grant.
- Sits between the client blocks (CSR writer, debug console, etc.) and the UART TX datapath.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: width of the transmitted data byte.
- TIMEOUT_CYCLES, 4096: watchdog limit on the wait for tx_done_i. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- rst_ni  in  1  synchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  NUM_REQ*DATA_W  packed bytes; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
- tx_data_o  out  DATA_W  held byte presented to the transmitter data register.
- tx_byte_ready_o  out  1  byte-ready strobe to the transmitter.
- tx_t_byte_o  out  1  load-shift-register strobe to the transmitter.
- tx_done_i  in  1  end-of-frame pulse from the transmitter (stop bit complete).
- grant_id_o  out  $clog2(NUM_REQ)  index of the requester currently owning the transmitter.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_ni low at a posedge):
  - state=IDLE, rr_ptr=0, hold_q=0.
  - All outputs 0; grant_id_o=0.
  - Applies from any state, including mid-frame. No strobe is emitted in the cycle after reset release.
- States: IDLE, LOAD, START, WAIT_DONE.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, scanning k=rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - If a winner exists, in the same cycle: req_ready_o[winner]=1 (combinational); at the edge, hold_q<=req_data_i[winner], grant_id_o<=winner, go to LOAD.
  - Otherwise stay in IDLE with req_ready_o=0.
  - Transfer happens when valid and ready are both high. Requesters must hold valid and data stable until ready.
- LOAD:
  - tx_byte_ready_o=1 for exactly one cycle; go to START.
  - tx_data_o=hold_q from LOAD onwards, stable until the next accept.
- START:
  - tx_t_byte_o=1 for exactly one cycle; go to WAIT_DONE.
- WAIT_DONE:
  - All strobes 0.
  - On tx_done_i=1: go to IDLE and set rr_ptr<=(grant_id_o+1) mod NUM_REQ (wrap at NUM_REQ-1 -> 0).
- Latency: accept edge to tx_byte_ready_o is 1 cycle; tx_byte_ready_o to tx_t_byte_o is 1 cycle.
- Throughput: earliest next accept is the cycle after tx_done_i, in IDLE.
- tx_done_i in IDLE, LOAD or START is ignored (no state change, no error).
- Simultaneous requests: exactly one grant. A requester that loses keeps valid high and is served in rotation. Maximum wait is NUM_REQ-1 frames.
- A valid dropped before its ready pulse is not an error; the scan simply skips that requester.
- Outputs req_ready_o, tx_byte_ready_o and tx_t_byte_o are never asserted together.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - Adds output port timeout_o (1 bit) and a $clog2(TIMEOUT_CYCLES+1)-bit counter, cleared on entry to WAIT_DONE.
  - If the counter reaches TIMEOUT_CYCLES with no tx_done_i: timeout_o pulses for 1 cycle, state goes to IDLE, and rr_ptr advances as if done.
  - tx_done_i in the same cycle as the limit counts as done; timeout_o stays 0.
- Undefined: no counter and no port; WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_pkg:
  - enum typedef uart_arb_state_e {IDLE, LOAD, START, WAIT_DONE} as 2-bit logic.
  - localparam UART_DATA_W=8.
- Sub-module rr_pick (combinational priority picker):
  - Inputs: NUM_REQ request vector and rr_ptr.
  - Outputs: found flag and winner index.
  - Reusable by other arbiters.

Test Plan:
- Single request: req_valid_i=4'b0100, byte 0xA5 -> req_ready_o=4'b0100 for 1 cycle; tx_byte_ready_o 1 cycle later; tx_t_byte_o the cycle after; tx_data_o=0xA5; grant_id_o=2; after tx_done_i, rr_ptr=3.
- Contention: all four valid from reset with bytes 0x10,0x11,0x12,0x13, done pulsed each frame -> grant order 0,1,2,3,0; tx_data_o sequence 0x10,0x11,0x12,0x13.
- Wrap: rr_ptr=3 with only req 3 and req 0 valid -> req 3 granted, then req 0 (ptr wraps 3->0).
- Spurious done: tx_done_i high during LOAD and START -> state still reaches WAIT_DONE; no early return to IDLE.
- Reset mid-frame: rst_ni low for 1 cycle while in WAIT_DONE -> next cycle IDLE, all outputs 0, grant_id_o=0, rr_ptr=0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: no tx_done_i -> timeout_o pulses 16 cycles after entering WAIT_DONE; next valid requester is granted the following cycle.
